uart_tx_scheduler: RTL and testbench

Shares one byte-wide UART transmitter between `NUM_REQ` independent byte-stream requesters. Arbitration is round-robin at packet granularity: a granted requester keeps the transmitter until it sends a byte flagged `last`. The block sits between application sources, such as status reporters and message generators, and the UART TX byte core. An optional gap enforces idle time between packets.

---
 rtl/uart_sched_pkg.sv | 19 +
 rtl/uart_rr_arbiter.sv | 47 ++++
 rtl/uart_tx_scheduler.sv | 136 +++++++++++++
 tb/tb_uart_tx_scheduler.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_sched_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_sched_pkg;

    localparam int MAX_REQ = 16;
    localparam logic [3:0] TAG_NIBBLE = 4'hA;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TAG  = 2'd1,
        DATA = 2'd2,
        GAP  = 2'd3
    } sched_state_e;

    // Source tag byte: fixed upper nibble, requester index in the lower nibble.
    function automatic logic [7:0] tag_byte(input logic [3:0] idx);
        return {TAG_NIBBLE, idx};
    endfunction

endpackage

// File: rtl/uart_rr_arbiter.sv
// Combinational rotate-priority arbiter: the search starts one position
// above the pointer and wraps, so the last winner has the lowest priority.
module uart_rr_arbiter
    import uart_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] gnt_oh_o,
    output logic [IDX_W-1:0]   gnt_idx_o,
    output logic               any_o
);

    logic             found_s;
    int               sum_s;
    logic [IDX_W-1:0] cand_s;

    // Walk the requesters starting at ptr+1 and keep the first asserted one.
    always_comb begin
        gnt_oh_o  = '0;
        gnt_idx_o = '0;
        found_s   = 1'b0;
        sum_s     = 0;
        cand_s    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            sum_s = int'(ptr_i) + 1 + i;
            if (sum_s >= NUM_REQ) begin
                sum_s = sum_s - NUM_REQ;
            end else begin
                sum_s = sum_s;
            end
            cand_s = IDX_W'(sum_s);
            if (!found_s && req_i[cand_s]) begin
                found_s          = 1'b1;
                gnt_oh_o[cand_s] = 1'b1;
                gnt_idx_o        = cand_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    assign any_o = |req_i;

endmodule

// File: rtl/uart_tx_scheduler.sv
// Packet-granular round-robin scheduler sharing one UART TX byte core
// between NUM_REQ byte-stream requesters, with an optional inter-packet gap.
// Optional feature: define UART_SCHED_SRC_TAG_EN to prefix every packet with
// a source tag byte {4'hA, index}.
module uart_tx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int GAP_CYCLES = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_REQ-1:0]   req_valid,
    input  logic [NUM_REQ*8-1:0] req_data,
    input  logic [NUM_REQ-1:0]   req_last,
    output logic [NUM_REQ-1:0]   req_ready,
    output logic                 tx_valid,
    output logic [7:0]           tx_data,
    input  logic                 tx_ready,
    output logic [NUM_REQ-1:0]   grant,
    output logic                 busy
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

    sched_state_e       state_q, state_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0]   gidx_q,  gidx_d;
    logic [IDX_W-1:0]   ptr_q,   ptr_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;

    logic [NUM_REQ-1:0] win_oh_s;
    logic [IDX_W-1:0]   win_idx_s;
    logic               win_any_s;

    uart_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_arb (
        .req_i     (req_valid),
        .ptr_i     (ptr_q),
        .gnt_oh_o  (win_oh_s),
        .gnt_idx_o (win_idx_s),
        .any_o     (win_any_s)
    );

    // State, ownership, round-robin pointer and gap counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= IDX_W'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic plus the combinational byte passthrough to the UART core.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        gidx_d    = gidx_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        tx_valid  = 1'b0;
        tx_data   = 8'h00;
        req_ready = '0;
        case (state_q)
            IDLE: begin
                if (win_any_s) begin
                    grant_d = win_oh_s;
                    gidx_d  = win_idx_s;
`ifdef UART_SCHED_SRC_TAG_EN
                    state_d = TAG;
`else
                    state_d = DATA;
`endif
                end else begin
                    state_d = IDLE;
                end
            end
`ifdef UART_SCHED_SRC_TAG_EN
            TAG: begin
                tx_valid = 1'b1;
                tx_data  = tag_byte(4'(gidx_q));
                if (tx_ready) begin
                    state_d = DATA;
                end else begin
                    state_d = TAG;
                end
            end
`endif
            DATA: begin
                // The owner keeps the core until its last byte, even while stalled.
                tx_valid          = req_valid[gidx_q];
                tx_data           = req_data[{gidx_q, 3'b000} +: 8];
                req_ready[gidx_q] = tx_ready;
                if (req_valid[gidx_q] && tx_ready && req_last[gidx_q]) begin
                    ptr_d   = gidx_q;
                    grant_d = '0;
                    if (GAP_CYCLES > 0) begin
                        state_d = GAP;
                        cnt_d   = GAP_LOAD;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    state_d = DATA;
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    assign grant = grant_q;
    assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed, table-driven bench for uart_tx_scheduler (NUM_REQ=4).
// dut0 runs with GAP_CYCLES=0, dut1 with GAP_CYCLES=4.
module tb_uart_tx_scheduler;

    logic clk;
    logic rst_n;

    logic [3:0]  d0_valid, d0_last, d0_ready, d0_grant;
    logic [31:0] d0_data;
    logic        d0_txr, d0_tx_valid, d0_busy;
    logic [7:0]  d0_tx_data;

    logic [3:0]  d1_valid, d1_last, d1_ready, d1_grant;
    logic [31:0] d1_data;
    logic        d1_txr, d1_tx_valid, d1_busy;
    logic [7:0]  d1_tx_data;

    int checks = 0;
    int errors = 0;

    uart_tx_scheduler #(.NUM_REQ(4), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(d0_valid), .req_data(d0_data), .req_last(d0_last),
        .req_ready(d0_ready), .tx_valid(d0_tx_valid), .tx_data(d0_tx_data),
        .tx_ready(d0_txr), .grant(d0_grant), .busy(d0_busy)
    );

    uart_tx_scheduler #(.NUM_REQ(4), .GAP_CYCLES(4)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(d1_valid), .req_data(d1_data), .req_last(d1_last),
        .req_ready(d1_ready), .tx_valid(d1_tx_valid), .tx_data(d1_tx_data),
        .tx_ready(d1_txr), .grant(d1_grant), .busy(d1_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [31:0] data;
        logic [3:0]  last;
        logic        txr;
        logic        etv;
        logic [7:0]  etd;
        logic [3:0]  err;
        logic [3:0]  eg;
        logic        eb;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic rst, input logic [3:0] valid, input logic [31:0] data,
                       input logic [3:0] last, input logic txr, input logic etv,
                       input logic [7:0] etd, input logic [3:0] err, input logic [3:0] eg,
                       input logic eb);
        vec_t v;
        v = '{rst, valid, data, last, txr, etv, etd, err, eg, eb};
        vecs.push_back(v);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        d0_valid = 4'b0000; d0_data = 32'h0; d0_last = 4'b0000; d0_txr = 1'b1;
        d1_valid = 4'b0000; d1_data = 32'h0; d1_last = 4'b0000; d1_txr = 1'b1;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] got[$];
        logic [7:0] exp2 [8];
        int cnt0, cnt2, done_c;
        logic acc1, acc3;
        logic        g_tv [9];
        logic        g_b  [9];
        logic [3:0]  g_g  [9];
        logic [3:0]  g_rr [9];
        logic [7:0]  g_td [9];

        rst_n = 1'b0;
        d0_valid = 4'b0000; d0_data = 32'h0; d0_last = 4'b0000; d0_txr = 1'b0;
        d1_valid = 4'b0000; d1_data = 32'h0; d1_last = 4'b0000; d1_txr = 1'b0;

`ifdef UART_SCHED_SRC_TAG_EN
        // req2 single-byte packet: tag 0xA2 then 0x55
        add(0, 4'b0100, 32'h00550000, 4'b0100, 1'b1, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0);
        add(0, 4'b0100, 32'h00550000, 4'b0100, 1'b1, 1'b1, 8'hA2, 4'b0000, 4'b0100, 1'b1);
        add(0, 4'b0100, 32'h00550000, 4'b0100, 1'b1, 1'b1, 8'h55, 4'b0100, 4'b0100, 1'b1);
        add(0, 4'b0000, 32'h00000000, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0);
`else
        // req0 sends 0x11 0x22 0x33 back to back
        add(0, 4'b0001, 32'h00000011, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0);
        add(0, 4'b0001, 32'h00000011, 4'b0000, 1'b1, 1'b1, 8'h11, 4'b0001, 4'b0001, 1'b1);
        add(0, 4'b0001, 32'h00000022, 4'b0000, 1'b1, 1'b1, 8'h22, 4'b0001, 4'b0001, 1'b1);
        add(0, 4'b0001, 32'h00000033, 4'b0001, 1'b1, 1'b1, 8'h33, 4'b0001, 4'b0001, 1'b1);
        add(0, 4'b0000, 32'h00000000, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0);
        // reset restores pointer so req0 wins next
        add(1, 4'b0000, 32'h00000000, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0);
        // owner req0 stalls 5 cycles while req1 waits
        add(0, 4'b0011, 32'h0000B0A0, 4'b0010, 1'b1, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0);
        add(0, 4'b0011, 32'h0000B0A0, 4'b0010, 1'b1, 1'b1, 8'hA0, 4'b0001, 4'b0001, 1'b1);
        for (int i = 0; i < 5; i++)
            add(0, 4'b0010, 32'h0000B0A1, 4'b0010, 1'b1, 1'b0, 8'hA1, 4'b0001, 4'b0001, 1'b1);
        add(0, 4'b0011, 32'h0000B0A1, 4'b0011, 1'b1, 1'b1, 8'hA1, 4'b0001, 4'b0001, 1'b1);
        add(0, 4'b0010, 32'h0000B000, 4'b0010, 1'b1, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0);
        // tx_ready low stalls req1's single byte
        add(0, 4'b0010, 32'h0000B000, 4'b0010, 1'b0, 1'b1, 8'hB0, 4'b0000, 4'b0010, 1'b1);
        add(0, 4'b0010, 32'h0000B000, 4'b0010, 1'b1, 1'b1, 8'hB0, 4'b0010, 4'b0010, 1'b1);
        add(0, 4'b0000, 32'h00000000, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0);
        // req3 starts a packet, reset aborts it, req0 then has priority
        add(0, 4'b1000, 32'hC0000000, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0);
        add(0, 4'b1000, 32'hC0000000, 4'b0000, 1'b1, 1'b1, 8'hC0, 4'b1000, 4'b1000, 1'b1);
        add(1, 4'b1001, 32'hC10000D0, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0);
        add(0, 4'b1001, 32'hC10000D0, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0);
        add(0, 4'b1001, 32'hC10000D0, 4'b0000, 1'b1, 1'b1, 8'hD0, 4'b0001, 4'b0001, 1'b1);
        add(0, 4'b1001, 32'hC10000D1, 4'b0001, 1'b1, 1'b1, 8'hD1, 4'b0001, 4'b0001, 1'b1);
        add(0, 4'b1000, 32'hC1000000, 4'b1000, 1'b1, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0);
        add(0, 4'b1000, 32'hC1000000, 4'b1000, 1'b1, 1'b1, 8'hC1, 4'b1000, 4'b1000, 1'b1);
        add(0, 4'b0000, 32'h00000000, 4'b0000, 1'b1, 1'b0, 8'h00, 4'b0000, 4'b0000, 1'b0);
`endif

        repeat (3) @(posedge clk);
        #1;
        chk("reset_tx_valid", {31'b0, d0_tx_valid}, 32'd0);
        chk("reset_busy",     {31'b0, d0_busy},     32'd0);
        rst_n = 1'b1;

        // Table: one vector per cycle, inputs driven after the edge, outputs sampled 1ns later
        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk); #1;
            rst_n    = !vecs[i].rst;
            d0_valid = vecs[i].valid;
            d0_data  = vecs[i].data;
            d0_last  = vecs[i].last;
            d0_txr   = vecs[i].txr;
            #1;
            chk($sformatf("v%0d_tx_valid", i),  {31'b0, d0_tx_valid}, {31'b0, vecs[i].etv});
            chk($sformatf("v%0d_tx_data", i),   {24'b0, d0_tx_data},  {24'b0, vecs[i].etd});
            chk($sformatf("v%0d_req_ready", i), {28'b0, d0_ready},    {28'b0, vecs[i].err});
            chk($sformatf("v%0d_grant", i),     {28'b0, d0_grant},    {28'b0, vecs[i].eg});
            chk($sformatf("v%0d_busy", i),      {31'b0, d0_busy},     {31'b0, vecs[i].eb});
        end

`ifndef UART_SCHED_SRC_TAG_EN
        // req0 and req2 both stream two 2-byte packets: order 0,2,0,2
        do_reset();
        exp2 = '{8'h00, 8'h01, 8'h20, 8'h21, 8'h02, 8'h03, 8'h22, 8'h23};
        cnt0 = 0; cnt2 = 0; done_c = -1;
        for (int c = 0; c < 40 && done_c < 0; c++) begin
            @(posedge clk); #1;
            d0_valid = {1'b0, cnt2 < 4, 1'b0, cnt0 < 4};
            d0_data  = {8'h00, 4'h2, 4'(cnt2), 8'h00, 4'h0, 4'(cnt0)};
            d0_last  = {1'b0, (cnt2 % 2) == 1, 1'b0, (cnt0 % 2) == 1};
            d0_txr   = 1'b1;
            #1;
            if (d0_tx_valid && d0_txr) got.push_back(d0_tx_data);
            if (d0_ready[0] && d0_valid[0]) cnt0++;
            if (d0_ready[2] && d0_valid[2]) cnt2++;
            if (got.size() == 8) done_c = c;
        end
        chk("rr_byte_count", got.size(), 32'd8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("rr_byte%0d", i), (i < got.size()) ? {24'b0, got[i]} : 32'hFFFF_FFFF,
                {24'b0, exp2[i]});
        chk("rr_last_byte_cycle", done_c, 32'd11);

        // GAP_CYCLES=4: req1 then req3 single-byte packets
        do_reset();
        d0_valid = 4'b0000;
        g_tv = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        g_b  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        g_g  = '{4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0};
        g_rr = '{4'h0, 4'h2, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h8, 4'h0};
        g_td = '{8'h00, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h3C, 8'h00};
        acc1 = 1'b0; acc3 = 1'b0;
        for (int c = 0; c < 9; c++) begin
            @(posedge clk); #1;
            d1_valid = {!acc3, 1'b0, !acc1, 1'b0};
            d1_data  = 32'h3C005A00;
            d1_last  = 4'b1010;
            d1_txr   = 1'b1;
            #1;
            chk($sformatf("gap%0d_tx_valid", c),  {31'b0, d1_tx_valid}, {31'b0, g_tv[c]});
            chk($sformatf("gap%0d_tx_data", c),   {24'b0, d1_tx_data},  {24'b0, g_td[c]});
            chk($sformatf("gap%0d_busy", c),      {31'b0, d1_busy},     {31'b0, g_b[c]});
            chk($sformatf("gap%0d_grant", c),     {28'b0, d1_grant},    {28'b0, g_g[c]});
            chk($sformatf("gap%0d_req_ready", c), {28'b0, d1_ready},    {28'b0, g_rr[c]});
            if (d1_ready[1] && d1_valid[1]) acc1 = 1'b1;
            if (d1_ready[3] && d1_valid[3]) acc3 = 1'b1;
        end
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
